traffic_phase_scheduler: RTL and testbench

Demand-driven two-road intersection controller: it sequences road A and road B signal heads through green/yellow/all-red phases. Phase lengths follow vehicle-sensor demand, with minimum and maximum green bounds. Pedestrian requests get an optional all-red walk phase. It replaces fixed-cycle light sequencing at the top of the intersection design; its light outputs drive the signal heads directly.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_phase_scheduler_if.sv | 24 ++
 rtl/demand_latch.sv | 29 ++
 rtl/traffic_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: state codes, light encodings
// and default phase durations.
package traffic_pkg;

  localparam logic [2:0] A_GREEN    = 3'd0;
  localparam logic [2:0] A_YELLOW   = 3'd1;
  localparam logic [2:0] ALL_RED_AB = 3'd2;
  localparam logic [2:0] B_GREEN    = 3'd3;
  localparam logic [2:0] B_YELLOW   = 3'd4;
  localparam logic [2:0] ALL_RED_BA = 3'd5;
  localparam logic [2:0] PED_WALK   = 3'd6;

  typedef logic [2:0] light_t;

  localparam light_t GREEN  = 3'b001;
  localparam light_t YELLOW = 3'b010;
  localparam light_t RED    = 3'b100;

  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned DEF_GREEN_MIN = 4;
  localparam int unsigned DEF_GREEN_MAX = 10;
  localparam int unsigned DEF_YELLOW_T  = 3;
  localparam int unsigned DEF_ALLRED_T  = 1;
  localparam int unsigned DEF_PED_T     = 5;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor inputs and signal-head outputs of the phase scheduler, bundled as one interface.
// CNT_W must match the scheduler's CNT_W.
interface traffic_phase_scheduler_if #(
  parameter int unsigned CNT_W = 4
);
  logic             carA;
  logic             carB;
  logic             ped_req;
  logic [2:0]       lightA;
  logic [2:0]       lightB;
  logic             walk;
  logic [CNT_W-1:0] count;
  logic [2:0]       phase;

  modport master (
    output carA, carB, ped_req,
    input  lightA, lightB, walk, count, phase
  );

  modport slave (
    input  carA, carB, ped_req,
    output lightA, lightB, walk, count, phase
  );
endinterface

// File: rtl/demand_latch.sv
// Sticky request flag: set_i latches it, clr_i drops it; clear wins on a same-cycle set.
module demand_latch (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clr_i) begin
      flag_d = 1'b0;
    end else if (set_i) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign q_o = flag_q;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-road signal controller with min/max green and all-red clearance.
// Define PED_SCHED_EN to latch ped_req and enable the all-red pedestrian walk phase.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned GREEN_MIN = DEF_GREEN_MIN,
  parameter int unsigned GREEN_MAX = DEF_GREEN_MAX,
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
  parameter int unsigned PED_T     = DEF_PED_T
) (
  input logic                      clk,
  input logic                      rst,
  traffic_phase_scheduler_if.slave tps_io
);

  localparam logic [CNT_W-1:0] GMin = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMax = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YelT = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ArT  = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] One  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dem_a, dem_b, ped_pend;
  logic             hold;
  logic             other_a, other_b;

  // Competing demand as seen from each road's green; latched values only.
  assign other_a = dem_b | ped_pend;
  assign other_b = dem_a | ped_pend;

`ifdef PED_SCHED_EN
  localparam logic [CNT_W-1:0] PedT = CNT_W'(PED_T);
  logic walk_to_b_q, walk_to_b_d;

  // Remembers which road the walk phase hands over to.
  always_comb begin
    walk_to_b_d = walk_to_b_q;
    if (state_q == ALL_RED_AB) begin
      walk_to_b_d = 1'b1;
    end else if (state_q == ALL_RED_BA) begin
      walk_to_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_to_b_q <= 1'b0;
    end else begin
      walk_to_b_q <= walk_to_b_d;
    end
  end
`else
  localparam int unsigned unused_ped_t = PED_T;
`endif

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    case (state_q)
      A_GREEN: begin
        if (other_a && ((count_q >= GMin && !tps_io.carA) || count_q == GMax)) begin
          state_d = A_YELLOW;
        end else if (count_q == GMax) begin
          hold = 1'b1;
        end
      end
      A_YELLOW:   if (count_q == YelT) state_d = ALL_RED_AB;
      ALL_RED_AB: if (count_q == ArT) state_d = ped_pend ? PED_WALK : B_GREEN;
      B_GREEN: begin
        if (other_b && ((count_q >= GMin && !tps_io.carB) || count_q == GMax)) begin
          state_d = B_YELLOW;
        end else if (count_q == GMax) begin
          hold = 1'b1;
        end
      end
      B_YELLOW:   if (count_q == YelT) state_d = ALL_RED_BA;
      ALL_RED_BA: if (count_q == ArT) state_d = ped_pend ? PED_WALK : A_GREEN;
`ifdef PED_SCHED_EN
      PED_WALK:   if (count_q == PedT) state_d = walk_to_b_q ? B_GREEN : A_GREEN;
`endif
      default:    state_d = A_GREEN;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      count_d = One;
    end else if (hold) begin
      count_d = count_q;
    end else begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_GREEN;
      count_q <= One;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  demand_latch u_dem_a (
    .clk   (clk),
    .rst   (rst),
    .set_i (tps_io.carA && (state_q != A_GREEN)),
    .clr_i ((state_d == A_GREEN) && (state_q != A_GREEN)),
    .q_o   (dem_a)
  );

  demand_latch u_dem_b (
    .clk   (clk),
    .rst   (rst),
    .set_i (tps_io.carB && (state_q != B_GREEN)),
    .clr_i ((state_d == B_GREEN) && (state_q != B_GREEN)),
    .q_o   (dem_b)
  );

`ifdef PED_SCHED_EN
  demand_latch u_ped (
    .clk   (clk),
    .rst   (rst),
    .set_i (tps_io.ped_req && (state_q != PED_WALK)),
    .clr_i ((state_d == PED_WALK) && (state_q != PED_WALK)),
    .q_o   (ped_pend)
  );

  assign tps_io.walk = (state_q == PED_WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = tps_io.ped_req;
  assign ped_pend       = 1'b0;
  assign tps_io.walk    = 1'b0;
`endif

  always_comb begin
    tps_io.lightA = RED;
    tps_io.lightB = RED;
    case (state_q)
      A_GREEN:  tps_io.lightA = GREEN;
      A_YELLOW: tps_io.lightA = YELLOW;
      B_GREEN:  tps_io.lightB = GREEN;
      B_YELLOW: tps_io.lightB = YELLOW;
      default: begin
        tps_io.lightA = RED;
        tps_io.lightB = RED;
      end
    endcase
  end

  assign tps_io.phase = state_q;
  assign tps_io.count = count_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed scenarios plus random sensor traffic
// checked against a phase-rule reference model.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned GREEN_MIN = 4;
  localparam int unsigned GREEN_MAX = 10;
  localparam int unsigned YELLOW_T  = 3;
  localparam int unsigned ALLRED_T  = 1;
  localparam int unsigned PED_T     = 5;
`ifdef PED_SCHED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if #(.CNT_W(CNT_W)) tps_if ();

  traffic_phase_scheduler #(
    .CNT_W     (CNT_W),
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .PED_T     (PED_T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tps_io (tps_if.slave)
  );

  typedef struct packed {
    logic [2:0] phase;
    logic [3:0] count;
    logic [2:0] la;
    logic [2:0] lb;
    logic       walk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase number 0..6 as in the phase table, 1-based elapsed count.
  int m_ph, m_cnt;
  bit m_dem_a, m_dem_b, m_ped, m_after_b;

  function automatic int fixed_len(input int ph);
    case (ph)
      1, 4:    return YELLOW_T;
      2, 5:    return ALLRED_T;
      6:       return PED_T;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] head(input int ph, input bit road_b);
    if (ph == (road_b ? 3 : 0)) return GREEN;
    if (ph == (road_b ? 4 : 1)) return YELLOW;
    return RED;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.phase = 3'(m_ph);
    e.count = 4'(m_cnt);
    e.la    = head(m_ph, 1'b0);
    e.lb    = head(m_ph, 1'b1);
    e.walk  = (m_ph == 6);
    return e;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 1;
    m_dem_a = 0; m_dem_b = 0; m_ped = 0; m_after_b = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit p);
    int nxt;
    bit own, rival;
    nxt = m_ph;
    if (m_ph == 0 || m_ph == 3) begin
      own   = (m_ph == 0) ? a : b;
      rival = ((m_ph == 0) ? m_dem_b : m_dem_a) || m_ped;
      if (rival && (m_cnt == GREEN_MAX || (m_cnt >= GREEN_MIN && !own))) nxt = m_ph + 1;
    end else if (m_cnt == fixed_len(m_ph)) begin
      case (m_ph)
        1:       nxt = 2;
        4:       nxt = 5;
        2:       nxt = m_ped ? 6 : 3;
        5:       nxt = m_ped ? 6 : 0;
        default: nxt = m_after_b ? 3 : 0;
      endcase
    end
    if (m_ph == 2) m_after_b = 1;
    else if (m_ph == 5) m_after_b = 0;
    if (a && m_ph != 0) m_dem_a = 1;
    if (b && m_ph != 3) m_dem_b = 1;
    if (PED_EN && p && m_ph != 6) m_ped = 1;
    if (nxt != m_ph) begin
      if (nxt == 0) m_dem_a = 0;
      if (nxt == 3) m_dem_b = 0;
      if (nxt == 6) m_ped = 0;
      m_cnt = 1;
    end else if (!((m_ph == 0 || m_ph == 3) && m_cnt == GREEN_MAX)) begin
      m_cnt = m_cnt + 1;
    end
    m_ph = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, queue what the next rising edge must show.
  task automatic cycle(input bit r, input bit a, input bit b, input bit p);
    bit was_rst;
    was_rst        = rst;
    rst            = r;
    tps_if.carA    = a;
    tps_if.carB    = b;
    tps_if.ped_req = p;
    if (r) model_reset();
    else model_step(a, b, p);
    exp_q.push_back(model_exp());
    if (r && !was_rst) begin
      #1;
      chk("async_rst_phase", 32'(tps_if.phase), 32'(A_GREEN));
      chk("async_rst_count", 32'(tps_if.count), 32'd1);
      chk("async_rst_lightA", 32'(tps_if.lightA), 32'(GREEN));
      chk("async_rst_lightB", 32'(tps_if.lightB), 32'(RED));
      chk("async_rst_walk", 32'(tps_if.walk), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("phase", 32'(tps_if.phase), 32'(e.phase));
        chk("count", 32'(tps_if.count), 32'(e.count));
        chk("lightA", 32'(tps_if.lightA), 32'(e.la));
        chk("lightB", 32'(tps_if.lightB), 32'(e.lb));
        chk("walk", 32'(tps_if.walk), 32'(e.walk));
      end
    end
  end

  initial begin : stimulus
    bit found;
    tps_if.carA = 1'b0; tps_if.carB = 1'b0; tps_if.ped_req = 1'b0;
    model_reset();

    // Idle: A green holds, count saturates.
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0);

    // Gap-out on a single carB pulse.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0);

    // Max-out with carA held.
    cycle(1, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 1, 0);
    for (int i = 0; i < 18; i++) cycle(0, 1, 0, 0);

    // Pedestrian request during A green.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 1);
    for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0);

    // Reset at count=2 of B yellow with A demand latched.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_ph == 4 && m_cnt == 2 && m_dem_a) found = 1'b1;
      else cycle(0, m_ph == 3, 0, 0);
    end
    chk("reach_b_yellow_c2", 32'(found), 32'd1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
